// File: rtl/pipe_in_assembler_if.sv
// Handshake bundle between the host word stream and the PipeIn enqueue port.
// master = word source / message sink, slave = assembler.
interface pipe_in_assembler_if #(
    parameter int WORD_W    = 32,
    parameter int TAG_W     = 16,
    parameter int PAYLOAD_W = 128
);
    logic                       word_valid;
    logic                       word_ready;
    logic [WORD_W-1:0]          word_data;
    logic                       pipe_enq__ENA;
    logic [TAG_W+PAYLOAD_W-1:0] pipe_enq_v;
    logic                       pipe_enq__RDY;

    modport master (
        output word_valid,
        output word_data,
        output pipe_enq__RDY,
        input  word_ready,
        input  pipe_enq__ENA,
        input  pipe_enq_v
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  pipe_enq__RDY,
        output word_ready,
        output pipe_enq__ENA,
        output pipe_enq_v
    );
endinterface

// File: rtl/pipe_in_assembler.sv
// Packs a header word plus 0..N payload words into one {payload, tag}
// PipeIn message, held in a one-entry output buffer with ENA/RDY handoff.
module pipe_in_assembler #(
    parameter int WORD_W    = 32,
    parameter int TAG_W     = 16,
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    pipe_in_assembler_if.slave  io,
    output logic [CNT_W-1:0]    msg_count,
    output logic                err_overlen
);
    localparam int MAX_WORDS = PAYLOAD_W / WORD_W;
    localparam int LEN_W     = WORD_W - TAG_W;
    localparam int MSG_W     = TAG_W + PAYLOAD_W;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TAG_W-1:0]       r_tag;
    logic [TAG_W-1:0]       w_tag_nxt;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_idx;
    logic [PAYLOAD_W-1:0]   r_payload;
    logic [PAYLOAD_W-1:0]   w_payload_nxt;
    logic [MSG_W-1:0]       r_buf;
    logic                   r_ena;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_err;

    logic                   w_ready;
    logic                   w_fire;
    logic                   w_deq;
    logic                   w_done;
    logic                   w_load;
    logic [LEN_W-1:0]       w_hdr_len;

    assign w_ready   = nRST && (r_state != S_WAIT);
    assign w_fire    = io.word_valid && w_ready;
    assign w_deq     = r_ena && io.pipe_enq__RDY;
    assign w_hdr_len = io.word_data[WORD_W-1:TAG_W];

    assign io.word_ready    = w_ready;
    assign io.pipe_enq__ENA = r_ena;
    assign io.pipe_enq_v    = r_buf;
    assign msg_count        = r_cnt;
    assign err_overlen      = r_err;

    // Next state, assembled message and buffer-load decision.
    always_comb begin
        w_state_nxt   = r_state;
        w_tag_nxt     = r_tag;
        w_payload_nxt = r_payload;
        w_done        = 1'b0;
        w_load        = 1'b0;
        unique case (r_state)
            S_HDR: begin
                if (w_fire) begin
                    w_tag_nxt     = io.word_data[TAG_W-1:0];
                    w_payload_nxt = '0;
                    if (w_hdr_len == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_fire) begin
                    for (int k = 0; k < MAX_WORDS; k++) begin
                        if (r_idx == LEN_W'(k)) begin
                            w_payload_nxt[k*WORD_W +: WORD_W] = io.word_data;
                        end
                    end
                    if (r_idx == r_len - LEN_W'(1)) begin
                        w_done = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_deq) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_HDR;
                end
            end
            default: begin
                w_state_nxt = S_HDR;
            end
        endcase
        if (w_done) begin
            if (!r_ena || w_deq) begin
                w_load      = 1'b1;
                w_state_nxt = S_HDR;
            end else begin
                w_state_nxt = S_WAIT;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Header capture, word index, accumulator, output buffer and counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_tag     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_payload <= '0;
            r_buf     <= '0;
            r_ena     <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_fire && (r_state == S_HDR)) begin
                r_len <= w_hdr_len;
                r_idx <= '0;
                if (w_hdr_len > LEN_W'(MAX_WORDS)) begin
                    r_err <= 1'b1;
                end
            end else if (w_fire) begin
                r_idx <= r_idx + LEN_W'(1);
            end
            r_tag     <= w_tag_nxt;
            r_payload <= w_payload_nxt;
            if (w_load) begin
                r_buf <= {w_payload_nxt, w_tag_nxt};
                r_ena <= 1'b1;
            end else if (w_deq) begin
                r_ena <= 1'b0;
            end
            if (w_deq) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipe_in_assembler.sv
// Self-checking bench for pipe_in_assembler: directed vectors plus a
// queue-based message model checked on every dequeue.
module tb_pipe_in_assembler;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] msg_count;
    logic        err_overlen;

    always #5 CLK = ~CLK;

    pipe_in_assembler_if #(
        .WORD_W(32), .TAG_W(16), .PAYLOAD_W(128)
    ) bus ();

    pipe_in_assembler #(
        .WORD_W(32), .TAG_W(16), .PAYLOAD_W(128), .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .io(bus.slave),
        .msg_count(msg_count),
        .err_overlen(err_overlen)
    );

    int           nerr = 0;
    int           nchk = 0;
    logic [143:0] exp_q[$];
    int           deq_cnt = 0;
    bit           m_err = 0;
    bit           chk_en = 0;
    bit           rnd_mode = 0;
    bit           rnd_gaps = 0;
    logic         rdy_dir = 1'b0;
    bit           prev_stall = 0;
    logic [143:0] prev_v;

    task automatic chk(input string name, input logic [143:0] act,
                       input logic [143:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    // Single driver of RDY: random in stress mode, directed otherwise.
    always @(posedge CLK) begin
        #2;
        bus.pipe_enq__RDY = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_dir;
    end

    // Per-cycle comparison against the message model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("msg_count", {128'h0, msg_count}, {128'h0, deq_cnt[15:0]});
            chk("err_overlen", {143'h0, err_overlen}, {143'h0, m_err});
            if (prev_stall) begin
                chk("stall_ena", {143'h0, bus.pipe_enq__ENA}, 144'h1);
                chk("stall_hold", bus.pipe_enq_v, prev_v);
            end
            if (bus.pipe_enq__ENA && bus.pipe_enq__RDY) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_msg: got %h expected none",
                             bus.pipe_enq_v);
                end else begin
                    chk("msg", bus.pipe_enq_v, exp_q.pop_front());
                end
                deq_cnt++;
            end
            prev_stall = bus.pipe_enq__ENA && !bus.pipe_enq__RDY;
            prev_v     = bus.pipe_enq_v;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        bit done = 0;
        if (rnd_gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.word_valid = 1'b0;
                sync();
            end
        end
        bus.word_valid = 1'b1;
        bus.word_data  = w;
        while (!done) begin
            @(negedge CLK);
            if (bus.word_ready) begin
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    nchk++;
                    nerr++;
                    $display("FAIL word_timeout: word %h not accepted", w);
                    done = 1;
                end
            end
        end
        sync();
        bus.word_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] hdr, input logic [31:0] ws [8]);
        int           len;
        logic [127:0] pay;
        len = int'(hdr[31:16]);
        pay = '0;
        for (int i = 0; i < len && i < 4; i++) pay[i*32 +: 32] = ws[i];
        exp_q.push_back({pay, hdr[15:0]});
        send_word(hdr);
        if (len > 4) m_err = 1;
        for (int i = 0; i < len && i < 8; i++) send_word(ws[i]);
    endtask

    task automatic do_reset(input int cyc);
        sync();
        nRST = 1'b0;
        chk_en = 0;
        bus.word_valid = 1'b0;
        repeat (cyc) @(posedge CLK);
        #1;
        exp_q.delete();
        deq_cnt = 0;
        m_err = 0;
        nRST = 1'b1;
        chk_en = 1;
    endtask

    initial begin
        logic [31:0] ws [8];
        int          n;
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
        rdy_dir        = 1'b1;
        nRST           = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", {143'h0, bus.word_ready}, 144'h0);
        chk("rst_ena", {143'h0, bus.pipe_enq__ENA}, 144'h0);
        chk("rst_v", bus.pipe_enq_v, 144'h0);
        chk("rst_count", {128'h0, msg_count}, 144'h0);
        chk("rst_err", {143'h0, err_overlen}, 144'h0);
        sync();
        nRST   = 1'b1;
        chk_en = 1;

        ws = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               32'h0, 32'h0, 32'h0, 32'h0};
        send_msg(32'h0004_00A5, ws);
        @(negedge CLK);
        chk("t1_ena", {143'h0, bus.pipe_enq__ENA}, 144'h1);
        chk("t1_v", bus.pipe_enq_v,
            144'h44444444_33333333_22222222_11111111_00A5);
        @(negedge CLK);
        chk("t1_count", {128'h0, msg_count}, 144'h1);
        chk("t1_ena_drop", {143'h0, bus.pipe_enq__ENA}, 144'h0);
        sync();

        ws[0] = 32'hDEADBEEF;
        send_msg(32'h0001_0007, ws);
        @(negedge CLK);
        chk("t2_v", bus.pipe_enq_v, {96'h0, 32'hDEADBEEF, 16'h0007});
        sync();
        send_msg(32'h0000_0009, ws);
        @(negedge CLK);
        chk("t2_zero_ena", {143'h0, bus.pipe_enq__ENA}, 144'h1);
        chk("t2_zero_v", bus.pipe_enq_v, {128'h0, 16'h0009});
        sync();

        do_reset(2);
        rdy_dir = 1'b0;
        ws[0] = 32'hAAAA0001;
        send_msg(32'h0001_0011, ws);
        ws[0] = 32'hBBBB0002;
        send_msg(32'h0001_0022, ws);
        @(negedge CLK);
        chk("t3_wait_ready", {143'h0, bus.word_ready}, 144'h0);
        chk("t3_first_held", bus.pipe_enq_v, {96'h0, 32'hAAAA0001, 16'h0011});
        sync();
        rdy_dir = 1'b1;
        @(negedge CLK);
        chk("t3_first", bus.pipe_enq_v, {96'h0, 32'hAAAA0001, 16'h0011});
        @(negedge CLK);
        chk("t3_second_ena", {143'h0, bus.pipe_enq__ENA}, 144'h1);
        chk("t3_second", bus.pipe_enq_v, {96'h0, 32'hBBBB0002, 16'h0022});
        @(negedge CLK);
        chk("t3_idle", {143'h0, bus.pipe_enq__ENA}, 144'h0);
        chk("t3_count", {128'h0, msg_count}, 144'h2);
        sync();

        ws = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd0, 32'd0};
        send_msg(32'h0006_0003, ws);
        @(negedge CLK);
        chk("t4_v", bus.pipe_enq_v,
            {32'd4, 32'd3, 32'd2, 32'd1, 16'h0003});
        chk("t4_err", {143'h0, err_overlen}, 144'h1);
        sync();
        ws[0] = 32'd7;
        ws[1] = 32'd8;
        send_msg(32'h0002_0004, ws);
        @(negedge CLK);
        chk("t4_next_v", bus.pipe_enq_v, {64'h0, 32'd8, 32'd7, 16'h0004});
        chk("t4_err_sticky", {143'h0, err_overlen}, 144'h1);
        sync();

        send_word(32'h0004_0001);
        send_word(32'hCAFE0001);
        send_word(32'hCAFE0002);
        do_reset(2);
        ws[0] = 32'h00000055;
        send_msg(32'h0001_0002, ws);
        @(negedge CLK);
        chk("t5_ena", {143'h0, bus.pipe_enq__ENA}, 144'h1);
        chk("t5_v", bus.pipe_enq_v, {96'h0, 32'h55, 16'h0002});
        @(negedge CLK);
        chk("t5_count", {128'h0, msg_count}, 144'h1);
        chk("t5_err", {143'h0, err_overlen}, 144'h0);
        sync();

        do_reset(2);
        rnd_mode = 1;
        rnd_gaps = 1;
        for (int m = 0; m < 1000; m++) begin
            logic [15:0] len;
            len = 16'($urandom_range(0, 4));
            for (int i = 0; i < 8; i++) ws[i] = $urandom;
            send_msg({len, 16'($urandom)}, ws);
        end
        bus.word_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain_timeout: %0d messages left, required 0",
                     exp_q.size());
        end
        rnd_mode = 0;
        rdy_dir  = 1'b1;
        sync();
        @(negedge CLK);
        chk("t6_count", {128'h0, msg_count}, 144'd1000);
        chk("t6_deq", 144'(deq_cnt), 144'd1000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
